// File: rtl/csi2_frame_gate_ctrl.sv
// Capture sequencer between the CSI-2 packet decoder and the RAW10 converter:
// frame-aligned start/stop, frame decimation, line/byte geometry checks.
module csi2_frame_gate_ctrl #(
  parameter int LANES  = 4,
  parameter int DW     = 32,
  parameter int LINE_W = 12,
  parameter int BYTE_W = 16,
  parameter int SKIP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_single,
  input  logic [SKIP_W-1:0] cfg_skip,
  input  logic [LINE_W-1:0] cfg_exp_lines,
  input  logic [BYTE_W-1:0] cfg_exp_bytes,
  input  logic              err_clr,
  input  logic              fv_i,
  input  logic              lv_i,
  input  logic [DW-1:0]     din,
  output logic              fv_o,
  output logic              lv_o,
  output logic [DW-1:0]     dout,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o,
  output logic [LINE_W-1:0] line_cnt_o,
  output logic              err_lines_o,
  output logic              err_bytes_o
);

  typedef enum logic [1:0] {IDLE, ARMED, PASS, DROP} state_t;

  state_t            state_q;
  logic              fv_r_q, lv_r_q;
  logic              single_q, stop_pend_q;
  logic [SKIP_W-1:0] skip_cnt_q;
  logic [LINE_W-1:0] line_ctr_q, line_cnt_q;
  logic [BYTE_W-1:0] byte_ctr_q;
  logic              fv_o_q, lv_o_q, frame_done_q, err_lines_q, err_bytes_q;
  logic [DW-1:0]     dout_q;
  logic [15:0]       frame_cnt_q;

  logic              lv_eff, fv_rise, fv_fall, line_end;
  logic              pass_now, frame_close, bytes_bad, lines_bad;
  logic [LINE_W-1:0] line_base, line_ctr_d;
  logic [BYTE_W-1:0] byte_base, byte_ctr_d;
  logic [BYTE_W:0]   byte_sum;

  // lv outside fv is ignored everywhere, so edges are taken on the gated line valid;
  // this also closes a line when fv drops while lv is still high.
  always_comb begin
    lv_eff      = lv_i & fv_i;
    fv_rise     = fv_i & ~fv_r_q;
    fv_fall     = ~fv_i & fv_r_q;
    line_end    = lv_r_q & ~lv_eff;
    pass_now    = (state_q == PASS) ||
                  ((state_q == ARMED) && fv_rise && (skip_cnt_q == '0) && !cfg_stop);
    frame_close = (state_q == PASS) && fv_fall;

    line_base   = fv_rise ? '0 : line_ctr_q;
    line_ctr_d  = line_base;
    if (line_end && (line_base != '1))
      line_ctr_d = line_base + LINE_W'(1);

    byte_base   = (fv_rise || line_end) ? '0 : byte_ctr_q;
    byte_sum    = {1'b0, byte_base} + (BYTE_W+1)'(LANES);
    byte_ctr_d  = byte_base;
    if (lv_eff)
      byte_ctr_d = byte_sum[BYTE_W] ? '1 : byte_sum[BYTE_W-1:0];

    bytes_bad   = pass_now && line_end && (cfg_exp_bytes != '0) &&
                  (byte_ctr_q != cfg_exp_bytes);
    lines_bad   = frame_close && (cfg_exp_lines != '0) && (line_ctr_d != cfg_exp_lines);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fv_r_q       <= 1'b0;
      lv_r_q       <= 1'b0;
      single_q     <= 1'b0;
      stop_pend_q  <= 1'b0;
      skip_cnt_q   <= '0;
      line_ctr_q   <= '0;
      line_cnt_q   <= '0;
      byte_ctr_q   <= '0;
      fv_o_q       <= 1'b0;
      lv_o_q       <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_lines_q  <= 1'b0;
      err_bytes_q  <= 1'b0;
    end else begin
      fv_r_q       <= fv_i;
      lv_r_q       <= lv_eff;
      frame_done_q <= frame_close;
      err_bytes_q  <= bytes_bad | (err_bytes_q & ~err_clr);
      err_lines_q  <= lines_bad | (err_lines_q & ~err_clr);

      if (pass_now) begin
        fv_o_q     <= fv_i;
        lv_o_q     <= lv_eff;
        dout_q     <= din;
        line_ctr_q <= line_ctr_d;
        byte_ctr_q <= byte_ctr_d;
      end else begin
        fv_o_q     <= 1'b0;
        lv_o_q     <= 1'b0;
      end

      if (frame_close) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        line_cnt_q  <= line_ctr_d;
      end

      case (state_q)
        IDLE: begin
          stop_pend_q <= 1'b0;
          if (cfg_start && !cfg_stop) begin
            state_q    <= ARMED;
            single_q   <= cfg_single;
            skip_cnt_q <= '0;
          end
        end
        ARMED: begin
          if (cfg_stop) begin
            state_q <= IDLE;
          end else if (fv_rise) begin
            if (skip_cnt_q == '0) begin
              state_q    <= PASS;
              skip_cnt_q <= cfg_skip;
            end else begin
              state_q    <= DROP;
              skip_cnt_q <= skip_cnt_q - SKIP_W'(1);
            end
          end
        end
        PASS: begin
          if (cfg_stop) stop_pend_q <= 1'b1;
          if (fv_fall) begin
            if (stop_pend_q || cfg_stop || single_q) begin
              state_q     <= IDLE;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= ARMED;
            end
          end
        end
        DROP: begin
          if (cfg_stop) stop_pend_q <= 1'b1;
          if (fv_fall) begin
            if (stop_pend_q || cfg_stop) begin
              state_q     <= IDLE;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= ARMED;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fv_o         = fv_o_q;
  assign lv_o         = lv_o_q;
  assign dout         = dout_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign line_cnt_o   = line_cnt_q;
  assign err_lines_o  = err_lines_q;
  assign err_bytes_o  = err_bytes_q;

endmodule

// File: tb/tb_csi2_frame_gate_ctrl.sv
// Bench for csi2_frame_gate_ctrl: frame-level reference model compared every cycle,
// plus literal expectations at the end of each scenario.
module tb_csi2_frame_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_single = 1'b0, err_clr = 1'b0;
  logic [3:0]  cfg_skip = '0;
  logic [11:0] cfg_exp_lines = '0;
  logic [15:0] cfg_exp_bytes = '0;
  logic        fv_i = 1'b0, lv_i = 1'b0;
  logic [31:0] din = '0;

  logic        fv_o, lv_o, busy_o, frame_done_o, err_lines_o, err_bytes_o;
  logic [31:0] dout;
  logic [15:0] frame_cnt_o;
  logic [11:0] line_cnt_o;

  always #5 clk = ~clk;

  csi2_frame_gate_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_single(cfg_single), .cfg_skip(cfg_skip), .cfg_exp_lines(cfg_exp_lines),
    .cfg_exp_bytes(cfg_exp_bytes), .err_clr(err_clr), .fv_i(fv_i), .lv_i(lv_i),
    .din(din), .fv_o(fv_o), .lv_o(lv_o), .dout(dout), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o), .line_cnt_o(line_cnt_o),
    .err_lines_o(err_lines_o), .err_bytes_o(err_bytes_o)
  );

  localparam int OFF = 0, WAIT = 1, TAKE = 2, SKIP = 3;
  localparam logic [3:0] S = 4'd1, P = 4'd2, C = 4'd4, R = 4'd8;

  // Reference: which frames are taken, and what a taken frame measures.
  int          mode = OFF, skip_left = 0, lines = 0, bytes_n = 0, m_fcnt = 0, m_lcnt = 0;
  logic        single_m = 0, stop_req = 0, pfv = 0, plv = 0;
  logic        m_fvo = 0, m_lvo = 0, m_done = 0, m_el = 0, m_eb = 0;
  logic [31:0] m_dout = '0;

  logic        e_fvo = 0, e_lvo = 0, e_done = 0, e_el = 0, e_eb = 0, e_busy = 0;
  logic [31:0] e_dout = '0;
  int          e_fcnt = 0, e_lcnt = 0;
  logic        chk_en = 0;

  int c_tot = 0, c_bad = 0, n_done = 0;
  int lit_id [128];
  int lit_exp[128];
  int lit_wr = 0, lit_rd = 0;

  task automatic model_step();
    logic rise, fall, lve, lend, taking, setb, setl;
    if (rst) begin
      mode = OFF; skip_left = 0; lines = 0; bytes_n = 0; m_fcnt = 0; m_lcnt = 0;
      single_m = 0; stop_req = 0; pfv = 0; plv = 0;
      m_fvo = 0; m_lvo = 0; m_done = 0; m_el = 0; m_eb = 0; m_dout = '0;
      return;
    end
    lve  = lv_i & fv_i;
    rise = fv_i & !pfv;
    fall = !fv_i & pfv;
    lend = plv & !lve;
    setb = 0; setl = 0; m_done = 0;
    taking = (mode == TAKE) || (mode == WAIT && rise && skip_left == 0 && !cfg_stop);
    if (taking) begin
      m_fvo = fv_i; m_lvo = lve; m_dout = din;
      if (rise) begin lines = 0; bytes_n = 0; end
      if (lend) begin
        if (cfg_exp_bytes != 0 && bytes_n != int'(cfg_exp_bytes)) setb = 1;
        lines   = (lines < 4095) ? lines + 1 : 4095;
        bytes_n = 0;
      end
      if (lve) bytes_n = (bytes_n + 4 > 65535) ? 65535 : bytes_n + 4;
      if (mode == TAKE && fall) begin
        m_done = 1;
        m_fcnt = (m_fcnt + 1) % 65536;
        m_lcnt = lines;
        if (cfg_exp_lines != 0 && lines != int'(cfg_exp_lines)) setl = 1;
      end
    end else begin
      m_fvo = 0; m_lvo = 0;
    end
    m_eb = setb ? 1'b1 : (err_clr ? 1'b0 : m_eb);
    m_el = setl ? 1'b1 : (err_clr ? 1'b0 : m_el);
    case (mode)
      OFF: if (cfg_start && !cfg_stop) begin
        mode = WAIT; single_m = cfg_single; skip_left = 0;
      end
      WAIT: if (cfg_stop) mode = OFF;
      else if (rise) begin
        if (skip_left == 0) begin mode = TAKE; skip_left = int'(cfg_skip); end
        else begin mode = SKIP; skip_left = skip_left - 1; end
      end
      default: begin
        if (cfg_stop) stop_req = 1;
        if (fall) mode = (stop_req || (mode == TAKE && single_m)) ? OFF : WAIT;
      end
    endcase
    if (mode == OFF) stop_req = 0;
    pfv = fv_i;
    plv = lve;
  endtask

  task automatic tick(input logic f, input logic l, input logic [3:0] c);
    @(posedge clk);
    #1;
    e_fvo = m_fvo; e_lvo = m_lvo; e_dout = m_dout; e_done = m_done;
    e_el = m_el; e_eb = m_eb; e_fcnt = m_fcnt; e_lcnt = m_lcnt; e_busy = (mode != OFF);
    chk_en = 1;
    fv_i = f; lv_i = l; din = $urandom;
    cfg_start = c[0]; cfg_stop = c[1]; err_clr = c[2]; rst = c[3];
    model_step();
  endtask

  task automatic lit(input int id, input int e);
    lit_id[lit_wr]  = id;
    lit_exp[lit_wr] = e;
    lit_wr++;
  endtask

  task automatic send_frame(input int nl, input int len, input int short_idx,
                            input int ev_line, input logic [3:0] ev,
                            input bit clr_short, input bit abrupt);
    tick(1, 0, 0); tick(1, 0, 0);
    for (int i = 0; i < nl; i++) begin
      int n;
      n = (i == short_idx) ? len - 1 : len;
      for (int k = 0; k < n; k++) tick(1, 1, (i == ev_line && k == 0) ? ev : 4'd0);
      if (!(abrupt && i == nl - 1))
        for (int g = 0; g < 3; g++)
          tick(1, 0, (clr_short && i == short_idx && g == 0) ? C : 4'd0);
    end
    tick(0, abrupt, 0);
    for (int g = 0; g < 3; g++) tick(0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    c_tot++;
    if (a !== e) begin
      c_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (frame_done_o) n_done++;
      chk("fv_o", 32'(fv_o), 32'(e_fvo));
      chk("lv_o", 32'(lv_o), 32'(e_lvo));
      chk("dout", dout, e_dout);
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("frame_done_o", 32'(frame_done_o), 32'(e_done));
      chk("frame_cnt_o", 32'(frame_cnt_o), 32'(e_fcnt));
      chk("line_cnt_o", 32'(line_cnt_o), 32'(e_lcnt));
      chk("err_lines_o", 32'(err_lines_o), 32'(e_el));
      chk("err_bytes_o", 32'(err_bytes_o), 32'(e_eb));
      while (lit_rd < lit_wr) begin
        case (lit_id[lit_rd])
          0: chk("lit_frame_cnt", 32'(frame_cnt_o), 32'(lit_exp[lit_rd]));
          1: chk("lit_line_cnt", 32'(line_cnt_o), 32'(lit_exp[lit_rd]));
          2: chk("lit_err_lines", 32'(err_lines_o), 32'(lit_exp[lit_rd]));
          3: chk("lit_err_bytes", 32'(err_bytes_o), 32'(lit_exp[lit_rd]));
          4: chk("lit_busy", 32'(busy_o), 32'(lit_exp[lit_rd]));
          default: chk("lit_done_pulses", 32'(n_done), 32'(lit_exp[lit_rd]));
        endcase
        lit_rd++;
      end
    end
  end

  initial begin
    int d0;
    tick(0, 0, R); tick(0, 0, R); tick(0, 0, 0);
    lit(4, 0); lit(0, 0); lit(1, 0); lit(3, 0);

    // continuous capture, matching geometry
    cfg_exp_lines = 12'd4; cfg_exp_bytes = 16'd80;
    d0 = n_done;
    tick(0, 0, S);
    repeat (3) send_frame(4, 20, -1, -1, 0, 0, 0);
    tick(0, 0, P); tick(0, 0, 0);
    lit(0, 3); lit(1, 4); lit(2, 0); lit(3, 0); lit(4, 0); lit(5, d0 + 3);

    // start mid-frame: that frame is blocked, the next one passes
    tick(0, 0, 0);
    d0 = n_done;
    send_frame(4, 20, -1, 1, S, 0, 0);
    send_frame(4, 20, -1, -1, 0, 0, 0);
    tick(0, 0, P); tick(0, 0, 0);
    lit(0, 4); lit(5, d0 + 1);

    // decimation: pass one, drop two
    tick(0, 0, 0);
    cfg_exp_lines = 0; cfg_exp_bytes = 0; cfg_skip = 4'd2;
    d0 = n_done;
    tick(0, 0, S);
    repeat (7) send_frame(2, 6, -1, -1, 0, 0, 0);
    tick(0, 0, P); tick(0, 0, 0);
    lit(0, 7); lit(1, 2); lit(5, d0 + 3);
    cfg_skip = 4'd0;

    // stop during line 2: frame completes, following frame blocked
    tick(0, 0, 0);
    d0 = n_done;
    tick(0, 0, S);
    send_frame(4, 10, -1, 2, P, 0, 0);
    lit(4, 0);
    send_frame(4, 10, -1, -1, 0, 0, 0);
    lit(0, 8); lit(5, d0 + 1); lit(4, 0);

    // geometry mismatches, clear, and clear colliding with a new mismatch
    tick(0, 0, 0);
    cfg_exp_lines = 12'd5; cfg_exp_bytes = 16'd80;
    tick(0, 0, S);
    send_frame(4, 20, 1, -1, 0, 0, 0);
    lit(2, 1); lit(3, 1);
    tick(0, 0, C); tick(0, 0, 0);
    lit(2, 0); lit(3, 0);
    send_frame(4, 20, 1, -1, 0, 1, 0);
    lit(3, 1); lit(2, 1);
    tick(0, 0, P); tick(0, 0, C); tick(0, 0, 0);
    lit(2, 0); lit(3, 0);

    // single-frame capture
    cfg_exp_lines = 0; cfg_exp_bytes = 0; cfg_single = 1'b1;
    d0 = n_done;
    tick(0, 0, S);
    send_frame(3, 6, -1, -1, 0, 0, 0);
    send_frame(3, 6, -1, -1, 0, 0, 0);
    lit(5, d0 + 1); lit(4, 0); lit(0, 11); lit(1, 3);
    cfg_single = 1'b0;

    // fv falls while lv still high: last line still counted and checked
    cfg_exp_lines = 12'd4; cfg_exp_bytes = 16'd80;
    tick(0, 0, S);
    send_frame(4, 20, -1, -1, 0, 0, 1);
    tick(0, 0, P); tick(0, 0, 0);
    lit(0, 12); lit(1, 4); lit(2, 0); lit(3, 0);

    // reset in the middle of a passed frame
    cfg_exp_bytes = 16'd0;
    tick(0, 0, S);
    send_frame(4, 10, -1, 1, R, 0, 0);
    lit(0, 0); lit(1, 0); lit(4, 0); lit(2, 0); lit(3, 0);

    tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", c_tot, c_bad);
    $finish;
  end

endmodule

// File: doc/csi2_frame_gate_ctrl.md
Name: csi2_frame_gate_ctrl

Overview:
- Capture sequencer between the 4-lane CSI-2 packet decoder (8-bit-domain fv/lv/32-bit payload) and the RAW10 byte-to-pixel converter, both on the FIFO read clock.
- Starts and stops capture only on whole-frame boundaries and decimates frames.
- Measures lines per frame and bytes per line, flags mismatches against programmed geometry, and reports frame status.

Parameters:
LANES, 4, bytes accepted per cycle while lv_i high
DW, 32, payload width (8*LANES)
LINE_W, 12, line counter width
BYTE_W, 16, byte-per-line counter width (matches CSI-2 WC)
SKIP_W, 4, frame decimation field width

Ports:
clk  in  1  read-domain clock
rst  in  1  synchronous reset, active high
cfg_start  in  1  pulse: arm capture
cfg_stop  in  1  pulse: stop after current frame
cfg_single  in  1  1 = capture one frame then idle; sampled at cfg_start
cfg_skip  in  SKIP_W  pass one frame, drop cfg_skip frames, repeat
cfg_exp_lines  in  LINE_W  expected lines/frame, 0 = no check
cfg_exp_bytes  in  BYTE_W  expected bytes/line, 0 = no check
err_clr  in  1  pulse: clear sticky errors
fv_i  in  1  frame valid from packet decoder
lv_i  in  1  line valid from packet decoder
din  in  DW  payload from packet decoder
fv_o  out  1  gated frame valid to RAW10 converter
lv_o  out  1  gated line valid
dout  out  DW  registered payload
busy_o  out  1  state != IDLE
frame_done_o  out  1  one-cycle pulse at end of each passed frame
frame_cnt_o  out  16  passed frames since reset, wraps
line_cnt_o  out  LINE_W  line count of last completed passed frame
err_lines_o  out  1  sticky: line count != cfg_exp_lines
err_bytes_o  out  1  sticky: a line's bytes != cfg_exp_bytes

Behaviour:
- Reset: state IDLE; all outputs 0, including dout, counters and sticky flags.
- Edge detection: fv_r and lv_r are 1-cycle delayed copies.
  - fv_rise = fv_i & ~fv_r; fv_fall = ~fv_i & fv_r; lv_fall = ~lv_i & lv_r.
- States:
  - IDLE: fv_o, lv_o = 0. On cfg_start, latch single_q = cfg_single, skip_cnt = 0, go to ARMED.
  - ARMED: wait for fv_rise; never enter mid-frame. On fv_rise:
    - skip_cnt == 0 -> PASS, and skip_cnt loads cfg_skip.
    - otherwise -> DROP, and skip_cnt decrements.
  - PASS:
    - fv_o = fv_i, lv_o = lv_i & fv_i, dout = din; all registered, latency exactly 1 cycle.
    - On the fv_fall cycle: fv_o = 0; frame_done_o = 1 next cycle; frame_cnt_o +1; line_cnt_o <= line counter; line check runs.
    - Next state: IDLE if stop_pend or single_q, else ARMED.
  - DROP: fv_o, lv_o = 0; dout holds. On fv_fall: IDLE if stop_pend, else ARMED.
- cfg_stop:
  - In IDLE or ARMED: return to IDLE next cycle.
  - In PASS or DROP: set stop_pend; the frame completes, then IDLE. stop_pend clears on entering IDLE.
- cfg_start outside IDLE is ignored. cfg_start and cfg_stop in the same cycle: stop wins.
- Line counting (PASS only):
  - Counter clears on fv_rise and increments on each lv_fall.
  - Saturates at all-ones.
- Byte counting (PASS only):
  - Adds LANES each cycle lv_i = 1; clears on lv_fall after the check.
  - Saturates at all-ones.
- Checks:
  - err_bytes_o sets on lv_fall if cfg_exp_bytes != 0 and count != cfg_exp_bytes.
  - err_lines_o sets on fv_fall if cfg_exp_lines != 0 and count != cfg_exp_lines.
  - Lines and frames not fully inside PASS are never checked.
  - err_clr clears both; a set in the same cycle wins over the clear.
- lv_i high while fv_i low: lv_o forced 0, not counted.
- fv_i falling while lv_i high: the line counts and the byte check runs, same cycle as the frame close.
- frame_cnt_o wraps 0xFFFF -> 0.

Test Plan:
- Continuous, cfg_skip=0, 3 frames × 4 lines × 20 lv cycles, exp_lines=4, exp_bytes=80 -> 3 frame_done pulses; frame_cnt_o=3; line_cnt_o=4; no errors; fv_o/lv_o/dout equal inputs delayed 1 cycle.
- cfg_start asserted mid-frame (fv_i high) -> that frame fully blocked; next frame passes from its first cycle.
- cfg_skip=2, 7 frames -> frames 1, 4, 7 passed; frame_cnt_o=3.
- cfg_stop during line 2 of a passed frame -> frame completes; frame_done pulses; busy_o=0 the cycle after frame_done; the following frame is blocked.
- exp_bytes=80 with one line of 19 lv cycles (76 bytes), exp_lines=5 with 4 lines -> both sticky errors set; err_clr clears both; err_clr coinciding with a new mismatch leaves the flag set.
- cfg_single=1 -> exactly one frame passed, then IDLE. Reset asserted mid-PASS -> all outputs 0 next cycle.
